// File: rtl/mod_dmem_port_if.sv
// mod_dmem_port_if: system request/response bus between the data-memory
// port (master) and the memory system (slave).
//   bus_reqcyc  : request beat valid (master -> slave)
//   bus_reqack  : request beat accepted (slave -> master)
//   bus_req     : address or write-data beat (master -> slave)
//   bus_reqtag  : {write bit, tag} of the request (master -> slave)
//   bus_respcyc : response beat valid (slave -> master)
//   bus_resptag : response tag (slave -> master)
//   bus_resp    : response data beat (slave -> master)
//   bus_respack : response beat consumed (master -> slave)
// TAG_W must match the TAG_W of the mod_dmem_port it is connected to.
interface mod_dmem_port_if #(
    parameter int TAG_W = 4
);
    logic               bus_reqcyc;
    logic               bus_reqack;
    logic [63:0]        bus_req;
    logic [TAG_W:0]     bus_reqtag;
    logic               bus_respcyc;
    logic [TAG_W:0]     bus_resptag;
    logic [63:0]        bus_resp;
    logic               bus_respack;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resptag, bus_resp
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resptag, bus_resp
    );
endinterface

// File: rtl/mod_dmem_port.sv
// mod_dmem_port: data-memory access port behind the memory stage.
// Turns one load or store request into bus transactions:
//   loads  - line-aligned read, collect BEATS response beats, keep the
//            addressed 64-bit word, pulse o_load_done.
//   stores - address beat then data beat, hold o_store_opn until the
//            write acknowledge arrives.
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_data_reqFlag     : load request level (sampled in IDLE)
//   i_store_reqFlag    : store request level (sampled in IDLE, wins over load)
//   i_req_addr         : byte address of the access
//   i_store_data       : store write data
//   o_load_buffer      : loaded word
//   o_load_done        : one-cycle pulse, o_load_buffer valid
//   o_store_opn        : high while a store is outstanding
//   o_mem_err          : sticky misalignment / timeout flag
//   bus                : request/response bus, master side
// BEATS must be a power of two and at least 2.
module mod_dmem_port #(
    parameter int BEATS   = 8,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_data_reqFlag,
    input  logic                 i_store_reqFlag,
    input  logic [63:0]          i_req_addr,
    input  logic [63:0]          i_store_data,
    output logic [63:0]          o_load_buffer,
    output logic                 o_load_done,
    output logic                 o_store_opn,
    output logic                 o_mem_err,
    mod_dmem_port_if.master      bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LD_REQ  = 3'd1;
    localparam logic [2:0] S_LD_RESP = 3'd2;
    localparam logic [2:0] S_ST_ADDR = 3'd3;
    localparam logic [2:0] S_ST_DATA = 3'd4;
    localparam logic [2:0] S_ST_ACK  = 3'd5;

    localparam int          BEAT_W    = $clog2(BEATS);
    localparam int          TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [63:0] LINE_MASK = 64'(BEATS * 8 - 1);

    logic [2:0]         r_state;
    logic [63:0]        r_addr;
    logic [63:0]        r_data;
    logic [63:0]        r_load_buffer;
    logic [TAG_W-1:0]   r_tag;
    logic [BEAT_W-1:0]  r_beat;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_load_done;
    logic               r_store_opn;
    logic               r_mem_err;
    // Blocks IDLE for one cycle after a completion so a request flag the
    // memory stage has not yet dropped is not taken as a new request.
    logic               r_cooldown;

    logic               w_is_write;
    logic [TAG_W:0]     w_reqtag;
    logic               w_reqcyc;
    logic [63:0]        w_req;
    logic               w_resp_match;
    logic               w_respack;
    logic               w_progress;
    logic               w_timeout;
    logic [BEAT_W-1:0]  w_word_idx;

    assign w_is_write   = (r_state == S_ST_ADDR) || (r_state == S_ST_DATA) || (r_state == S_ST_ACK);
    assign w_reqtag     = {w_is_write, r_tag};
    assign w_reqcyc     = (r_state == S_LD_REQ) || (r_state == S_ST_ADDR) || (r_state == S_ST_DATA);
    // Only beats carrying the current tag (including the write bit) are
    // ours; anything else is left unacknowledged.
    assign w_resp_match = bus.bus_respcyc && (bus.bus_resptag == w_reqtag);
    assign w_respack    = w_resp_match && ((r_state == S_LD_RESP) || (r_state == S_ST_ACK));
    assign w_progress   = (w_reqcyc && bus.bus_reqack) || w_respack;
    assign w_timeout    = (r_tmo == TMO_W'(TIMEOUT));
    assign w_word_idx   = r_addr[BEAT_W+2:3];

    always_comb begin
        w_req = '0;
        case (r_state)
            S_LD_REQ:  w_req = r_addr & ~LINE_MASK;
            S_ST_ADDR: w_req = r_addr;
            S_ST_DATA: w_req = r_data;
            default:   w_req = '0;
        endcase
    end

    assign bus.bus_reqcyc  = w_reqcyc;
    assign bus.bus_req     = w_req;
    assign bus.bus_reqtag  = w_reqcyc ? w_reqtag : '0;
    assign bus.bus_respack = w_respack;

    assign o_load_buffer = r_load_buffer;
    assign o_load_done   = r_load_done;
    assign o_store_opn   = r_store_opn;
    assign o_mem_err     = r_mem_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_data        <= '0;
            r_load_buffer <= '0;
            r_tag         <= '0;
            r_beat        <= '0;
            r_tmo         <= '0;
            r_load_done   <= 1'b0;
            r_store_opn   <= 1'b0;
            r_mem_err     <= 1'b0;
            r_cooldown    <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_cooldown  <= 1'b0;

            if (r_state == S_IDLE || w_progress || w_timeout)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (!r_cooldown && (i_store_reqFlag || i_data_reqFlag)) begin
                        if (i_req_addr[2:0] != 3'b000) begin
                            // Refuse the access; a waiting load still gets
                            // its completion pulse so the stage can move on.
                            r_mem_err  <= 1'b1;
                            r_cooldown <= 1'b1;
                            if (i_data_reqFlag) begin
                                r_load_done   <= 1'b1;
                                r_load_buffer <= '0;
                            end
                        end else if (i_store_reqFlag) begin
                            r_addr      <= i_req_addr;
                            r_data      <= i_store_data;
                            r_store_opn <= 1'b1;
                            r_state     <= S_ST_ADDR;
                        end else begin
                            r_addr  <= i_req_addr;
                            r_beat  <= '0;
                            r_state <= S_LD_REQ;
                        end
                    end
                end
                S_LD_REQ, S_LD_RESP: begin
                    if (r_state == S_LD_REQ && bus.bus_reqack) begin
                        r_state <= S_LD_RESP;
                    end else if (w_respack) begin
                        if (r_beat == w_word_idx)
                            r_load_buffer <= bus.bus_resp;
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == BEAT_W'(BEATS - 1)) begin
                            r_load_done <= 1'b1;
                            r_tag       <= r_tag + 1'b1;
                            r_cooldown  <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end else if (w_timeout) begin
                        // Advance the tag so a late line is never mistaken
                        // for the next request's data.
                        r_mem_err   <= 1'b1;
                        r_load_done <= 1'b1;
                        r_tag       <= r_tag + 1'b1;
                        r_cooldown  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_ST_ADDR, S_ST_DATA, S_ST_ACK: begin
                    if (r_state == S_ST_ADDR && bus.bus_reqack) begin
                        r_state <= S_ST_DATA;
                    end else if (r_state == S_ST_DATA && bus.bus_reqack) begin
                        r_state <= S_ST_ACK;
                    end else if (w_respack || w_timeout) begin
                        if (w_timeout && !w_respack)
                            r_mem_err <= 1'b1;
                        r_store_opn <= 1'b0;
                        r_tag       <= r_tag + 1'b1;
                        r_cooldown  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_dmem_port.sv
module tb_mod_dmem_port;
    localparam int BEATS = 8;
    localparam int TAG_W = 4;

    logic        clk;
    logic        rst_n;
    logic        data_req;
    logic        store_req;
    logic [63:0] req_addr;
    logic [63:0] store_data;
    logic [63:0] load_buffer;
    logic        load_done;
    logic        store_opn;
    logic        mem_err;

    int n_checks = 0;
    int n_err    = 0;

    mod_dmem_port_if #(.TAG_W(TAG_W)) bus ();

    mod_dmem_port #(.BEATS(BEATS), .TAG_W(TAG_W), .TIMEOUT(1023)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_data_reqFlag  (data_req),
        .i_store_reqFlag (store_req),
        .i_req_addr      (req_addr),
        .i_store_data    (store_data),
        .o_load_buffer   (load_buffer),
        .o_load_done     (load_done),
        .o_store_opn     (store_opn),
        .o_mem_err       (mem_err),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serve one load from the slave side: wait for the request, accept it,
    // optionally present stale beats first, then return data_base+k beats.
    task automatic load_serve(input string name, input logic [63:0] line_exp,
                              input logic [TAG_W:0] tg, input int n_stale,
                              input logic [TAG_W:0] stale_tg, input logic [63:0] data_base,
                              output logic [63:0] word, output int cyc);
        int w;
        cyc = 0;
        w   = 0;
        while (!bus.bus_reqcyc && w < 20) begin
            @(negedge clk);
            w++;
            cyc++;
        end
        chk({name, "_reqcyc"}, 64'(bus.bus_reqcyc), 64'd1);
        chk({name, "_addr"}, bus.bus_req, line_exp);
        chk({name, "_tag"}, 64'(bus.bus_reqtag), 64'(tg));
        bus.bus_reqack = 1'b1;
        @(negedge clk);
        cyc++;
        bus.bus_reqack = 1'b0;
        chk({name, "_reqcyc_drop"}, 64'(bus.bus_reqcyc), 64'd0);
        for (int s = 0; s < n_stale; s++) begin
            bus.bus_respcyc = 1'b1;
            bus.bus_resptag = stale_tg;
            bus.bus_resp    = 64'hEEEE_0000 + 64'(s);
            #1;
            chk({name, "_stale_noack"}, 64'(bus.bus_respack), 64'd0);
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < BEATS; k++) begin
            bus.bus_respcyc = 1'b1;
            bus.bus_resptag = tg;
            bus.bus_resp    = data_base + 64'(k);
            #1;
            chk({name, "_respack"}, 64'(bus.bus_respack), 64'd1);
            @(negedge clk);
            cyc++;
        end
        bus.bus_respcyc = 1'b0;
        chk({name, "_done"}, 64'(load_done), 64'd1);
        word     = load_buffer;
        data_req = 1'b0;
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(load_done), 64'd0);
    endtask

    // Store from the slave side with stalled address/data acceptance and a
    // delayed write acknowledge.
    task automatic store_run(input string name, input logic [63:0] a, input logic [63:0] d,
                             input logic [TAG_W:0] tg, input int stall, input int ack_dly);
        store_req  = 1'b1;
        req_addr   = a;
        store_data = d;
        @(negedge clk);
        chk({name, "_opn"}, 64'(store_opn), 64'd1);
        chk({name, "_addr"}, bus.bus_req, a);
        chk({name, "_tag"}, 64'(bus.bus_reqtag), 64'(tg));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, "_addr_hold"}, 64'(bus.bus_reqcyc), 64'd1);
        end
        bus.bus_reqack = 1'b1;
        @(negedge clk);
        bus.bus_reqack = 1'b0;
        chk({name, "_data"}, bus.bus_req, d);
        chk({name, "_data_cyc"}, 64'(bus.bus_reqcyc), 64'd1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, "_data_hold"}, 64'(bus.bus_reqcyc), 64'd1);
        end
        bus.bus_reqack = 1'b1;
        @(negedge clk);
        bus.bus_reqack = 1'b0;
        chk({name, "_ack_wait_cyc"}, 64'(bus.bus_reqcyc), 64'd0);
        for (int i = 0; i < ack_dly; i++) begin
            chk({name, "_opn_hold"}, 64'(store_opn), 64'd1);
            @(negedge clk);
        end
        bus.bus_respcyc = 1'b1;
        bus.bus_resptag = tg;
        bus.bus_resp    = '0;
        #1;
        chk({name, "_respack"}, 64'(bus.bus_respack), 64'd1);
        @(negedge clk);
        bus.bus_respcyc = 1'b0;
        chk({name, "_opn_fall"}, 64'(store_opn), 64'd0);
        store_req = 1'b0;
    endtask

    logic [63:0] word;
    int          cyc;
    int          w;

    initial begin
        rst_n           = 1'b0;
        data_req        = 1'b0;
        store_req       = 1'b0;
        req_addr        = '0;
        store_data      = '0;
        bus.bus_reqack  = 1'b0;
        bus.bus_respcyc = 1'b0;
        bus.bus_resptag = '0;
        bus.bus_resp    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_reqcyc", 64'(bus.bus_reqcyc), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_opn", 64'(store_opn), 64'd0);
        chk("rst_err", 64'(mem_err), 64'd0);
        chk("rst_buf", load_buffer, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: plain load, word 3 of the line, 10-cycle latency
        data_req = 1'b1;
        req_addr = 64'h1018;
        load_serve("t1", 64'h1000, 5'h00, 0, 5'h00, 64'hA0, word, cyc);
        chk("t1_word", word, 64'hA3);
        chk("t1_latency", 64'(cyc), 64'd10);
        $display("t1 load 0x1018 word=%h latency=%0d", word, cyc);

        // 2: store with stalled phases and late write ack
        store_run("t2", 64'h2000, 64'hDEADBEEF, 5'h11, 3, 5);
        $display("t2 store 0x2000 done");
        @(negedge clk);

        // 3: load with stale beats of another tag in front
        data_req = 1'b1;
        req_addr = 64'h4028;
        load_serve("t3", 64'h4000, 5'h02, 2, 5'h12, 64'hC0, word, cyc);
        chk("t3_word", word, 64'hC5);
        $display("t3 load 0x4028 word=%h", word);

        // 4: store and load together, store goes first
        data_req = 1'b1;
        store_run("t4s", 64'h5008, 64'h1122334455667788, 5'h13, 0, 1);
        load_serve("t4l", 64'h5000, 5'h04, 0, 5'h00, 64'hD0, word, cyc);
        chk("t4_word", word, 64'hD1);
        $display("t4 store then load 0x5008 word=%h", word);

        // 5: misaligned load
        data_req = 1'b1;
        req_addr = 64'h1003;
        @(negedge clk);
        chk("t5_err", 64'(mem_err), 64'd1);
        chk("t5_done", 64'(load_done), 64'd1);
        chk("t5_buf", load_buffer, 64'd0);
        chk("t5_noreq", 64'(bus.bus_reqcyc), 64'd0);
        data_req = 1'b0;
        @(negedge clk);
        chk("t5_noreq2", 64'(bus.bus_reqcyc), 64'd0);
        $display("t5 misaligned load err=%0d", mem_err);

        // 6: reset in the middle of a load, then a fresh load
        data_req = 1'b1;
        req_addr = 64'h3030;
        @(negedge clk);
        chk("t6_tag", 64'(bus.bus_reqtag), 64'h05);
        bus.bus_reqack = 1'b1;
        @(negedge clk);
        bus.bus_reqack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.bus_respcyc = 1'b1;
            bus.bus_resptag = 5'h05;
            bus.bus_resp    = 64'h90 + 64'(k);
            @(negedge clk);
        end
        rst_n           = 1'b0;
        bus.bus_respcyc = 1'b0;
        data_req        = 1'b0;
        #1;
        chk("t6_rst_err", 64'(mem_err), 64'd0);
        chk("t6_rst_buf", load_buffer, 64'd0);
        chk("t6_rst_respack", 64'(bus.bus_respack), 64'd0);
        chk("t6_rst_reqcyc", 64'(bus.bus_reqcyc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        data_req = 1'b1;
        load_serve("t6", 64'h3000, 5'h00, 2, 5'h05, 64'hB0, word, cyc);
        chk("t6_word", word, 64'hB6);
        $display("t6 load after reset word=%h", word);

        // 7: store whose address is never accepted times out
        store_req = 1'b1;
        req_addr  = 64'h7000;
        repeat (500) @(negedge clk);
        chk("t7_opn_mid", 64'(store_opn), 64'd1);
        chk("t7_err_mid", 64'(mem_err), 64'd0);
        w = 0;
        while (store_opn && w < 700) begin
            @(negedge clk);
            w++;
        end
        chk("t7_opn_fall", 64'(store_opn), 64'd0);
        chk("t7_err", 64'(mem_err), 64'd1);
        store_req = 1'b0;
        $display("t7 store timeout err=%0d", mem_err);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
